// File: rtl/cpu_sequencer.sv
// Phase sequencer for the accumulator CPU: generates FETCH/EXEC1/EXEC2 strobes,
// latches IR/OPERAND, handles STP halt, single-step debug and retired-instruction count.
module cpu_sequencer #(
    parameter int              DATA_W   = 16,
    parameter int              OP_W     = 4,
    parameter int              CNT_W    = 16,
    parameter logic [OP_W-1:0] STP_CODE = 4'h7
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   EXTRA,
    input  logic [DATA_W-1:0]      MEM_Q,
    input  logic [DATA_W-1:0]      ACC,
    input  logic                   STEP_MODE,
    input  logic                   STEP,
    output logic                   FETCH,
    output logic                   EXEC1,
    output logic                   EXEC2,
    output logic [OP_W-1:0]        IR,
    output logic [DATA_W-OP_W-1:0] OPERAND,
    output logic                   EQ,
    output logic                   MI,
    output logic                   HALTED,
    output logic [CNT_W-1:0]       INSTR_CNT
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC1 = 2'd1,
        S_EXEC2 = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t                  state_q;
    logic                    step_q;
    logic [OP_W-1:0]         ir_q;
    logic [DATA_W-OP_W-1:0]  operand_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    halted_q;
    logic                    adv;

    // One advance per STEP rising edge in single-step mode, every cycle otherwise.
    assign adv = !STEP_MODE || (STEP && !step_q);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= S_FETCH;
            step_q    <= 1'b0;
            ir_q      <= '0;
            operand_q <= '0;
            cnt_q     <= '0;
            halted_q  <= 1'b0;
        end else begin
            step_q <= STEP;
            if (adv) begin
                case (state_q)
                    S_FETCH: begin
                        ir_q      <= MEM_Q[DATA_W-1 -: OP_W];
                        operand_q <= MEM_Q[DATA_W-OP_W-1:0];
                        state_q   <= S_EXEC1;
                    end
                    S_EXEC1: begin
                        cnt_q <= cnt_q + 1'b1;
                        if (ir_q == STP_CODE) begin
                            state_q  <= S_HALT;
                            halted_q <= 1'b1;
                        end else if (EXTRA) begin
                            state_q <= S_EXEC2;
                        end else begin
                            state_q <= S_FETCH;
                        end
                    end
                    S_EXEC2: state_q <= S_FETCH;
                    default: state_q <= S_HALT;
                endcase
            end
        end
    end

    // Strobes are gated by adv so each decoder side effect fires once per phase.
    assign FETCH     = (state_q == S_FETCH) && adv;
    assign EXEC1     = (state_q == S_EXEC1) && adv;
    assign EXEC2     = (state_q == S_EXEC2) && adv;
    assign IR        = ir_q;
    assign OPERAND   = operand_q;
    assign HALTED    = halted_q;
    assign INSTR_CNT = cnt_q;
    assign EQ        = (ACC == '0);
    assign MI        = ACC[DATA_W-1];

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: vector table for the free-run/STP path plus
// hand sequences for halt hold, single-step, counter wrap and mid-instruction reset.
module tb_cpu_sequencer;

    logic        CLK = 1'b0;
    logic        RESET, EXTRA, STEP_MODE, STEP;
    logic [15:0] MEM_Q, ACC;
    logic        FETCH, EXEC1, EXEC2, EQ, MI, HALTED;
    logic [3:0]  IR;
    logic [11:0] OPERAND;
    logic [15:0] INSTR_CNT;

    logic        w_fetch, w_exec1, w_exec2, w_eq, w_mi, w_halted;
    logic [3:0]  w_ir;
    logic [11:0] w_operand;
    logic [3:0]  w_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 CLK = ~CLK;

    cpu_sequencer dut (
        .CLK(CLK), .RESET(RESET), .EXTRA(EXTRA), .MEM_Q(MEM_Q), .ACC(ACC),
        .STEP_MODE(STEP_MODE), .STEP(STEP), .FETCH(FETCH), .EXEC1(EXEC1),
        .EXEC2(EXEC2), .IR(IR), .OPERAND(OPERAND), .EQ(EQ), .MI(MI),
        .HALTED(HALTED), .INSTR_CNT(INSTR_CNT)
    );

    // Narrow-counter copy on the same inputs so the wrap is reachable quickly.
    cpu_sequencer #(.CNT_W(4)) dut_w (
        .CLK(CLK), .RESET(RESET), .EXTRA(EXTRA), .MEM_Q(MEM_Q), .ACC(ACC),
        .STEP_MODE(STEP_MODE), .STEP(STEP), .FETCH(w_fetch), .EXEC1(w_exec1),
        .EXEC2(w_exec2), .IR(w_ir), .OPERAND(w_operand), .EQ(w_eq), .MI(w_mi),
        .HALTED(w_halted), .INSTR_CNT(w_cnt)
    );

    typedef struct {
        logic        step_mode;
        logic        step;
        logic        extra;
        logic [15:0] mem_q;
        logic [15:0] acc;
        logic        fetch;
        logic        exec1;
        logic        exec2;
        logic [3:0]  ir;
        logic [11:0] operand;
        logic        halted;
        logic [15:0] cnt;
        logic        eq;
        logic        mi;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic vec_t mk(logic sm, logic st, logic ex, logic [15:0] mq,
                                logic [15:0] ac, logic f, logic e1, logic e2,
                                logic [3:0] ir, logic [11:0] op, logic h,
                                logic [15:0] c, logic eq, logic mi);
        vec_t v;
        v.step_mode = sm; v.step = st; v.extra = ex; v.mem_q = mq; v.acc = ac;
        v.fetch = f; v.exec1 = e1; v.exec2 = e2; v.ir = ir; v.operand = op;
        v.halted = h; v.cnt = c; v.eq = eq; v.mi = mi;
        return v;
    endfunction

    task automatic do_reset(input logic sm);
        RESET = 1'b1; STEP_MODE = sm; STEP = 1'b0; EXTRA = 1'b0;
        MEM_Q = 16'h0000; ACC = 16'h0001;
        tick();
        RESET = 1'b0;
    endtask

    initial begin
        int fcnt, e1cnt;
        bit found;

        //                sm st ex mem      acc      F  E1 E2 IR    OPND     H  CNT  EQ MI
        vecs[0] = mk(0, 0, 0, 16'h2005, 16'h0000, 1, 0, 0, 4'h0, 12'h000, 0, 16'd0, 1, 0);
        vecs[1] = mk(0, 0, 1, 16'h0000, 16'h8001, 0, 1, 0, 4'h2, 12'h005, 0, 16'd0, 0, 1);
        vecs[2] = mk(0, 0, 0, 16'h0000, 16'h0001, 0, 0, 1, 4'h2, 12'h005, 0, 16'd1, 0, 0);
        vecs[3] = mk(0, 0, 0, 16'h4010, 16'h0000, 1, 0, 0, 4'h2, 12'h005, 0, 16'd1, 1, 0);
        vecs[4] = mk(0, 0, 0, 16'h0000, 16'h8001, 0, 1, 0, 4'h4, 12'h010, 0, 16'd1, 0, 1);
        vecs[5] = mk(0, 0, 1, 16'h7000, 16'h0001, 1, 0, 0, 4'h4, 12'h010, 0, 16'd2, 0, 0);
        vecs[6] = mk(0, 0, 1, 16'h0000, 16'h0001, 0, 1, 0, 4'h7, 12'h000, 0, 16'd2, 0, 0);
        vecs[7] = mk(0, 0, 1, 16'h0000, 16'h0001, 0, 0, 0, 4'h7, 12'h000, 1, 16'd3, 0, 0);
        vecs[8] = mk(1, 0, 0, 16'h2005, 16'h0000, 0, 0, 0, 4'h7, 12'h000, 1, 16'd3, 1, 0);
        vecs[9] = mk(1, 1, 0, 16'h2005, 16'h8001, 0, 0, 0, 4'h7, 12'h000, 1, 16'd3, 0, 1);

        do_reset(1'b0);
        for (int i = 0; i < 10; i++) begin
            STEP_MODE = vecs[i].step_mode; STEP = vecs[i].step; EXTRA = vecs[i].extra;
            MEM_Q = vecs[i].mem_q; ACC = vecs[i].acc;
            @(negedge CLK);
            chk("fetch", i, 32'(FETCH), 32'(vecs[i].fetch));
            chk("exec1", i, 32'(EXEC1), 32'(vecs[i].exec1));
            chk("exec2", i, 32'(EXEC2), 32'(vecs[i].exec2));
            chk("ir", i, 32'(IR), 32'(vecs[i].ir));
            chk("operand", i, 32'(OPERAND), 32'(vecs[i].operand));
            chk("halted", i, 32'(HALTED), 32'(vecs[i].halted));
            chk("instr_cnt", i, 32'(INSTR_CNT), 32'(vecs[i].cnt));
            chk("eq", i, 32'(EQ), 32'(vecs[i].eq));
            chk("mi", i, 32'(MI), 32'(vecs[i].mi));
            tick();
        end

        // Halt holds for 22 cycles while STEP/STEP_MODE toggle.
        fcnt = 0;
        for (int i = 0; i < 22; i++) begin
            STEP = i[0]; STEP_MODE = i[1]; EXTRA = 1'b1; ACC = 16'h0001;
            @(negedge CLK);
            if (FETCH || EXEC1 || EXEC2 || !HALTED || IR != 4'h7) fcnt++;
            tick();
        end
        chk("halt_hold_bad_cycles", 0, 32'(fcnt), 32'd0);
        chk("halt_cnt", 0, 32'(INSTR_CNT), 32'd3);

        do_reset(1'b0);
        @(negedge CLK);
        chk("post_halt_reset_fetch", 0, 32'(FETCH), 32'd1);
        chk("post_halt_reset_halted", 0, 32'(HALTED), 32'd0);
        chk("post_halt_reset_cnt", 0, 32'(INSTR_CNT), 32'd0);
        chk("post_halt_reset_ir", 0, 32'(IR), 32'd0);
        tick();

        // Single-step: held STEP yields one FETCH; IR stays put while MEM_Q changes.
        do_reset(1'b1);
        @(negedge CLK);
        chk("step_idle_fetch", 0, 32'(FETCH), 32'd0);
        tick();
        fcnt = 0; e1cnt = 0;
        for (int i = 0; i < 10; i++) begin
            STEP = 1'b1;
            MEM_Q = (i == 0) ? 16'h3123 : 16'h5555;
            @(negedge CLK);
            fcnt += int'(FETCH); e1cnt += int'(EXEC1);
            tick();
        end
        chk("step_held_fetch_pulses", 0, 32'(fcnt), 32'd1);
        chk("step_held_exec1_pulses", 0, 32'(e1cnt), 32'd0);
        chk("step_ir", 0, 32'(IR), 32'h3);
        chk("step_operand", 0, 32'(OPERAND), 32'h123);
        STEP = 1'b0;
        @(negedge CLK);
        chk("step_low_exec1", 0, 32'(EXEC1), 32'd0);
        tick();
        fcnt = 0; e1cnt = 0;
        for (int i = 0; i < 5; i++) begin
            STEP = 1'b1;
            @(negedge CLK);
            fcnt += int'(FETCH); e1cnt += int'(EXEC1);
            tick();
        end
        chk("step2_exec1_pulses", 0, 32'(e1cnt), 32'd1);
        chk("step2_fetch_pulses", 0, 32'(fcnt), 32'd0);
        chk("step2_ir", 0, 32'(IR), 32'h3);
        chk("step2_cnt", 0, 32'(INSTR_CNT), 32'd1);
        STEP_MODE = 1'b0;
        @(negedge CLK);
        chk("mode_switch_fetch", 0, 32'(FETCH), 32'd1);
        tick();

        // Counter wrap, seen on the 4-bit copy after 16 retired instructions.
        do_reset(1'b0);
        MEM_Q = 16'h1000;
        for (int i = 0; i < 30; i++) tick();
        @(negedge CLK);
        chk("wrap_pre_small", 0, 32'(w_cnt), 32'd15);
        chk("wrap_pre_main", 0, 32'(INSTR_CNT), 32'd15);
        tick(); tick();
        @(negedge CLK);
        chk("wrap_small", 0, 32'(w_cnt), 32'd0);
        chk("wrap_main", 0, 32'(INSTR_CNT), 32'd16);
        tick();

        // Reset asserted during EXEC2.
        MEM_Q = 16'h2005; EXTRA = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge CLK);
            if (EXEC2) found = 1'b1;
            else tick();
        end
        chk("exec2_reached", 0, 32'(found), 32'd1);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        @(negedge CLK);
        chk("rst_exec2_fetch", 0, 32'(FETCH), 32'd1);
        chk("rst_exec2_exec2", 0, 32'(EXEC2), 32'd0);
        chk("rst_exec2_ir", 0, 32'(IR), 32'd0);
        chk("rst_exec2_cnt", 0, 32'(INSTR_CNT), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
